// File: rtl/mini_alu_16bit_arbiter.sv
// mini_alu_16bit_arbiter: round-robin sharing of one add/subtract datapath between two requesters
module mini_alu_16bit_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_op,
  input  logic [DATA_WIDTH-1:0] req0_data0,
  input  logic [DATA_WIDTH-1:0] req0_data1,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_op,
  input  logic [DATA_WIDTH-1:0] req1_data0,
  input  logic [DATA_WIDTH-1:0] req1_data1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_ok,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);
  state_t                r_state;
  state_t                w_next;
  logic                  r_rr_ptr;
  logic [3:0]            r_cnt;
  logic                  r_op;
  logic                  r_id;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_rsp_id;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_overflow;
  logic                  r_ok;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_lt;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_res;
  // rr_ptr only breaks ties; a lone valid requester always wins
  assign w_grant0     = req0_valid & (~req1_valid | ~r_rr_ptr);
  assign w_grant1     = req1_valid & (~req0_valid | r_rr_ptr);
  assign req0_ready   = (r_state == IDLE) & w_grant0;
  assign req1_ready   = (r_state == IDLE) & w_grant1;
  assign w_accept     = req0_ready | req1_ready;
  assign w_done       = (r_state == EXEC) && (r_cnt == 4'd0);
  assign w_lt         = r_a < r_b;
  assign w_sum        = {1'b0, r_a} + {1'b0, r_b};
  assign w_res        = !r_op ? w_sum[DATA_WIDTH-1:0] : w_lt ? r_b - r_a : r_a - r_b;
  assign rsp_valid    = r_state == RESP;
  assign rsp_id       = r_rsp_id;
  assign rsp_result   = r_result;
  assign rsp_overflow = r_overflow;
  assign rsp_ok       = r_ok;
  assign busy         = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_accept ? EXEC : IDLE)
           : r_state == EXEC ? (r_cnt == 4'd0 ? RESP : EXEC)
           : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 1'b0;
      r_cnt      <= 4'd0;
      r_op       <= 1'b0;
      r_id       <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_id   <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_ok       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= req1_ready ? req1_op : req0_op;
        r_a   <= req1_ready ? req1_data0 : req0_data0;
        r_b   <= req1_ready ? req1_data1 : req0_data1;
        r_id  <= req1_ready;
        r_cnt <= CNT_INIT;
      end
      if (r_state == EXEC && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_done) begin
        r_result   <= w_res;
        r_overflow <= r_op ? w_lt : w_sum[DATA_WIDTH];
        r_ok       <= ~r_op | ~w_lt;
        r_rsp_id   <= r_id;
      end
      if (rsp_valid && rsp_ready) r_rr_ptr <= ~r_rsp_id;
    end
  end
endmodule

// File: tb/tb_mini_alu_16bit_arbiter.sv
// tb_mini_alu_16bit_arbiter: randomized self-checking bench against a behavioural ALU/arbiter model
module tb_mini_alu_16bit_arbiter;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit m_rr = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic v0 = 0, v1 = 0, op0 = 0, op1 = 0, rr = 1;
  logic [15:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic rd0, rd1, rv, rid, rovf, rok, bsy;
  logic [15:0] rres;

  logic x_v0 = 0, x_v1 = 0, x_op0 = 0, x_op1 = 0, x_rr = 1;
  logic [15:0] x_a0 = 0, x_b0 = 0, x_a1 = 0, x_b1 = 0;
  logic x_rd0, x_rd1, x_rv, x_rid, x_rovf, x_rok, x_bsy;
  logic [15:0] x_rres;

  mini_alu_16bit_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(rd0), .req0_op(op0), .req0_data0(a0), .req0_data1(b0),
    .req1_valid(v1), .req1_ready(rd1), .req1_op(op1), .req1_data0(a1), .req1_data1(b1),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid), .rsp_result(rres),
    .rsp_overflow(rovf), .rsp_ok(rok), .busy(bsy)
  );

  mini_alu_16bit_arbiter #(.DATA_WIDTH(16), .EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(x_v0), .req0_ready(x_rd0), .req0_op(x_op0), .req0_data0(x_a0), .req0_data1(x_b0),
    .req1_valid(x_v1), .req1_ready(x_rd1), .req1_op(x_op1), .req1_data0(x_a1), .req1_data1(x_b1),
    .rsp_valid(x_rv), .rsp_ready(x_rr), .rsp_id(x_rid), .rsp_result(x_rres),
    .rsp_overflow(x_rovf), .rsp_ok(x_rok), .busy(x_bsy)
  );

  // {result, overflow, ok} from plain integer arithmetic
  function automatic logic [17:0] model(input logic op, input logic [15:0] a, input logic [15:0] b);
    int unsigned ia = a;
    int unsigned ib = b;
    int unsigned s = ia + ib;
    if (!op) return {16'(s % 65536), s > 65535, 1'b1};
    if (ia >= ib) return {16'(ia - ib), 1'b0, 1'b1};
    return {16'(ib - ia), 1'b1, 1'b0};
  endfunction

  task automatic run_one(input bit who, input bit op, input logic [15:0] a, input logic [15:0] b,
                         output int t_acc, output int t_rsp, output logic [17:0] got, output logic gid);
    int g = 0;
    if (who) begin v1 = 1; op1 = op; a1 = a; b1 = b; end
    else begin v0 = 1; op0 = op; a0 = a; b0 = b; end
    t_acc = -1; t_rsp = -1; got = 'x; gid = 'x;
    while (t_acc < 0 && g < 20) begin
      #1;
      if (who ? rd1 : rd0) begin @(posedge clk); #1; t_acc = cyc; end
      else begin @(posedge clk); #1; end
      g++;
    end
    v0 = 0; v1 = 0;
    while (t_acc >= 0 && t_rsp < 0 && g < 60) begin
      if (rv) begin t_rsp = cyc; got = {rres, rovf, rok}; gid = rid; end
      else begin @(posedge clk); #1; end
      g++;
    end
    if (t_rsp >= 0) begin @(posedge clk); #1; m_rr = ~who; end
  endtask

  task automatic test_reset();
    int ta, tr, g;
    logic [17:0] got;
    logic gid;
    rst = 1; rr = 1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({rv, rid, rres, rovf, rok, bsy, rd0, rd1} !== 23'd0) begin
      $display("FAIL reset_values got=%h exp=0", {rv, rid, rres, rovf, rok, bsy, rd0, rd1}); n_fail++;
    end
    rst = 0; m_rr = 0;
    run_one(0, 0, 16'h1111, 16'h2222, ta, tr, got, gid);
    v0 = 1; op0 = 1; a0 = 16'd5; b0 = 16'd3; g = 0;
    #1;
    while (!rd0 && g < 10) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    v0 = 0;
    n_tests++;
    if (bsy !== 1'b1) begin $display("FAIL reset_inflight_busy got=%b exp=1", bsy); n_fail++; end
    rst = 1;
    #1;
    n_tests++;
    if ({rv, rid, rres, rovf, rok, bsy, rd0, rd1} !== 23'd0) begin
      $display("FAIL reset_midexec got=%h exp=0", {rv, rid, rres, rovf, rok, bsy, rd0, rd1}); n_fail++;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 0; m_rr = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({rv, bsy} !== 2'b00) begin $display("FAIL reset_no_rsp got=%b exp=00", {rv, bsy}); n_fail++; end
    end
  endtask

  task automatic test_add_latency();
    int ta, tr;
    logic [17:0] got;
    logic gid;
    run_one(0, 0, 16'h1234, 16'h0F0F, ta, tr, got, gid);
    n_tests++;
    if (tr < 0 || tr - ta !== 1) begin $display("FAIL add_latency got=%0d exp=1", tr - ta); n_fail++; end
    n_tests++;
    if ({got, gid} !== {16'h2143, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL add_result got=%h exp=%h", {got, gid}, {16'h2143, 1'b0, 1'b1, 1'b0}); n_fail++;
    end
    n_tests++;
    if (bsy !== 1'b0) begin $display("FAIL add_busy_after got=%b exp=0", bsy); n_fail++; end
  endtask

  task automatic test_sub_borrow();
    int ta, tr;
    logic [17:0] got;
    logic gid;
    run_one(1, 1, 16'h0003, 16'h0010, ta, tr, got, gid);
    n_tests++;
    if ({got, gid} !== {16'h000D, 1'b1, 1'b0, 1'b1}) begin
      $display("FAIL sub_borrow got=%h exp=%h", {got, gid}, {16'h000D, 1'b1, 1'b0, 1'b1}); n_fail++;
    end
    run_one(1, 1, 16'h0000, 16'hFFFF, ta, tr, got, gid);
    n_tests++;
    if (got !== {16'hFFFF, 1'b1, 1'b0}) begin
      $display("FAIL sub_zero_minus_max got=%h exp=%h", got, {16'hFFFF, 1'b1, 1'b0}); n_fail++;
    end
  endtask

  task automatic test_carry();
    int ta, tr;
    logic [17:0] got;
    logic gid;
    run_one(0, 0, 16'hFFFF, 16'h0001, ta, tr, got, gid);
    n_tests++;
    if (got !== {16'h0000, 1'b1, 1'b1}) begin
      $display("FAIL add_carry_wrap got=%h exp=%h", got, {16'h0000, 1'b1, 1'b1}); n_fail++;
    end
    run_one(1, 1, 16'h8000, 16'h8000, ta, tr, got, gid);
    n_tests++;
    if (got !== {16'h0000, 1'b0, 1'b1}) begin
      $display("FAIL sub_equal got=%h exp=%h", got, {16'h0000, 1'b0, 1'b1}); n_fail++;
    end
  endtask

  task automatic test_random();
    int ta, tr;
    logic [17:0] got, exp;
    logic gid;
    bit who, op;
    logic [15:0] a, b;
    for (int i = 0; i < 16; i++) begin
      who = 1'($urandom); op = 1'($urandom);
      a = 16'($urandom); b = (i % 4 == 0) ? a : 16'($urandom);
      exp = model(op, a, b);
      run_one(who, op, a, b, ta, tr, got, gid);
      n_tests++;
      if ({got, gid, 8'(tr - ta)} !== {exp, who, 8'd1}) begin
        $display("FAIL random_op%0d got=%h exp=%h", i, {got, gid, 8'(tr - ta)}, {exp, who, 8'd1}); n_fail++;
      end
    end
  endtask

  task automatic test_contention();
    int ta, tr, acc = 0, got = 0, g = 0;
    logic [17:0] res;
    logic gid;
    logic [15:0] pa = 0, pb = 0;
    logic po = 0;
    run_one(1, 0, 16'd1, 16'd1, ta, tr, res, gid);
    v0 = 1; v1 = 1;
    op0 = 1'($urandom); a0 = 16'($urandom); b0 = 16'($urandom);
    op1 = 1'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
    while (got < 6 && g < 100) begin
      g++;
      if (rv) begin
        n_tests++;
        if ({rid, rres, rovf, rok} !== {got[0], model(po, pa, pb)}) begin
          $display("FAIL contention_rsp%0d got=%h exp=%h", got, {rid, rres, rovf, rok}, {got[0], model(po, pa, pb)});
          n_fail++;
        end
        got++;
      end
      #1;
      if (rd0 | rd1) begin
        n_tests++;
        if ({rd0, rd1} !== (acc[0] ? 2'b01 : 2'b10)) begin
          $display("FAIL contention_grant%0d got=%b exp=%b", acc, {rd0, rd1}, acc[0] ? 2'b01 : 2'b10); n_fail++;
        end
        po = rd1 ? op1 : op0; pa = rd1 ? a1 : a0; pb = rd1 ? b1 : b0;
        acc++;
        @(posedge clk); #1;
        if (acc[0]) begin op0 = 1'($urandom); a0 = 16'($urandom); b0 = 16'($urandom); end
        else begin op1 = 1'($urandom); a1 = 16'($urandom); b1 = 16'($urandom); end
      end else begin
        @(posedge clk); #1;
      end
    end
    v0 = 0; v1 = 0; m_rr = 0;
    n_tests++;
    if (got != 6) begin $display("FAIL contention_timeout got=%0d exp=6", got); n_fail++; end
  endtask

  task automatic test_backpressure();
    int ta = -1, tr = -1, h, g = 0;
    logic [17:0] snap;
    logic [15:0] pa, pb;
    logic po;
    x_rr = 0; x_v0 = 1; x_op0 = 1'($urandom); x_a0 = 16'($urandom); x_b0 = 16'($urandom);
    while (ta < 0 && g < 20) begin
      #1;
      if (x_rd0) begin @(posedge clk); #1; ta = cyc; end
      else begin @(posedge clk); #1; end
      g++;
    end
    snap = model(x_op0, x_a0, x_b0);
    x_op0 = 0; x_a0 = 16'h00FF; x_b0 = 16'h0001;
    x_v1 = 1; x_op1 = 1'($urandom); x_a1 = 16'($urandom); x_b1 = 16'($urandom);
    while (ta >= 0 && tr < 0 && g < 60) begin
      if (x_rv) tr = cyc;
      else begin @(posedge clk); #1; end
      g++;
    end
    n_tests++;
    if (tr < 0 || tr - ta !== 3) begin $display("FAIL bp_latency got=%0d exp=3", tr - ta); n_fail++; end
    n_tests++;
    if ({x_rid, x_rres, x_rovf, x_rok} !== {1'b0, snap}) begin
      $display("FAIL bp_result got=%h exp=%h", {x_rid, x_rres, x_rovf, x_rok}, {1'b0, snap}); n_fail++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({x_rv, x_rid, x_rres, x_rovf, x_rok, x_rd0, x_rd1} !== {1'b1, 1'b0, snap, 2'b00}) begin
        $display("FAIL bp_hold%0d got=%h exp=%h", i, {x_rv, x_rid, x_rres, x_rovf, x_rok, x_rd0, x_rd1},
                 {1'b1, 1'b0, snap, 2'b00});
        n_fail++;
      end
    end
    x_rr = 1;
    #1;
    n_tests++;
    if ({x_rd0, x_rd1} !== 2'b00) begin $display("FAIL bp_no_accept_at_hs got=%b exp=00", {x_rd0, x_rd1}); n_fail++; end
    @(posedge clk); #1;
    h = cyc;
    n_tests++;
    if ({x_rv, x_rd0, x_rd1} !== 3'b001) begin
      $display("FAIL bp_next_accept got=%b exp=001", {x_rv, x_rd0, x_rd1}); n_fail++;
    end
    po = x_op1; pa = x_a1; pb = x_b1;
    @(posedge clk); #1;
    x_v0 = 0; x_v1 = 0;
    n_tests++;
    if (x_bsy !== 1'b1 || cyc != h + 1) begin $display("FAIL bp_accept_edge got=%b exp=1", x_bsy); n_fail++; end
    tr = -1; g = 0;
    while (tr < 0 && g < 20) begin
      if (x_rv) tr = cyc;
      else begin @(posedge clk); #1; end
      g++;
    end
    n_tests++;
    if (tr - (h + 1) !== 3 || {x_rid, x_rres, x_rovf, x_rok} !== {1'b1, model(po, pa, pb)}) begin
      $display("FAIL bp_second got=%h lat=%0d exp=%h lat=3", {x_rid, x_rres, x_rovf, x_rok}, tr - (h + 1),
               {1'b1, model(po, pa, pb)});
      n_fail++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    test_reset();
    test_add_latency();
    test_sub_borrow();
    test_carry();
    test_random();
    test_contention();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mini_alu_16bit_arbiter.md
Name: mini_alu_16bit_arbiter

Overview:
- Shares one 16-bit add/subtract datapath between two requesters.
- Round-robin arbitration; valid/ready handshake on every request and on the single response channel.
- Latency is programmable.
- Sits between the two issuing engines and the shared ALU. Subtract semantics match the team's SUB unit: a negative difference returns the absolute value, overflow=1, ok=0.

Parameters:
- DATA_WIDTH, 16, operand/result width (block verified at 16 only)
- EXEC_CYCLES, 1, cycles spent in EXEC before the result registers (legal range 1..15)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  1  0=ADD, 1=SUB
- req0_data0  input  DATA_WIDTH  operand A (minuend for SUB)
- req0_data1  input  DATA_WIDTH  operand B (subtrahend for SUB)
- req1_valid, req1_ready, req1_op, req1_data0, req1_data1: same as requester 0, for requester 1
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester index of this response
- rsp_result  output  DATA_WIDTH  sum or |difference|
- rsp_overflow  output  1  ADD: carry out; SUB: A<B
- rsp_ok  output  1  ADD: 1; SUB: ~(A<B)
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, named rst; clock named clk.
- Reset values:
  - state=IDLE, rr_ptr=0, exec counter=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, rsp_ok=0, busy=0.
  - req0_ready=req1_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqK_ready = (state==IDLE) & grantK. Combinational; depends on valid.
  - Grant rule: only one valid → grant it. Both valid → grant requester rr_ptr.
  - On a grant edge: latch op, data0, data1 and id; load counter=EXEC_CYCLES-1; go to EXEC.
  - No valid → stay in IDLE.
- EXEC:
  - Counter decrements each cycle.
  - At counter==0: register result/overflow/ok/id into the rsp_* outputs, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_* held stable while rsp_valid & ~rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid=0, rr_ptr = ~rsp_id, go to IDLE.
  - No accept in the same cycle as the response handshake; the earliest next accept is the following cycle.
- Latency:
  - Accept on edge T → rsp_valid high from edge T+EXEC_CYCLES.
  - With the default, 1 cycle after accept.
  - Throughput: one operation per EXEC_CYCLES+2 cycles with rsp_ready tied high.
- Arithmetic (modulo 2^DATA_WIDTH, unsigned):
  - ADD: result = A+B truncated; overflow = carry out; ok=1.
  - SUB, A>=B: result = A-B; overflow=0; ok=1.
  - SUB, A<B: result = B-A; overflow=1; ok=0.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1. rr_ptr updates only on response handshake.
- Requester protocol:
  - data/op must be held while valid & ~ready.
  - Deasserting valid before ready is legal; that request is simply dropped from arbitration.
- Outputs other than rsp_valid retain their last values in IDLE/EXEC (not cleared).
- Reset mid-operation (any state): immediate return to reset values. In-flight op discarded, no response emitted.
- Boundary values:
  - A=B → result 0, overflow 0, ok 1.
  - 0xFFFF+0x0001 → result 0x0000, overflow 1.
  - 0x0000-0xFFFF → result 0xFFFF, overflow 1, ok 0.

Test Plan:
- Reset check: assert rst mid-EXEC with req0 SUB 5-3 in flight → all outputs at reset values, no rsp_valid after release, busy=0.
- Single ADD latency: req0 ADD 0x1234+0x0F0F, rsp_ready=1 → req0_ready pulses at T; rsp_valid at T+1 with result 0x2143, overflow 0, ok 1, id 0; busy low at T+2.
- SUB borrow case: req1 SUB 0x0003-0x0010 → result 0x000D, overflow 1, ok 0, id 1. Then 0x0000-0xFFFF → 0xFFFF, overflow 1, ok 0.
- Carry wrap: ADD 0xFFFF+0x0001 → result 0x0000, overflow 1, ok 1. SUB 0x8000-0x8000 → 0x0000, overflow 0, ok 1.
- Contention fairness: both valid continuously for 6 ops, rsp_ready=1 → rsp_id sequence 0,1,0,1,0,1; each requester's data matches its own operands.
- Backpressure with EXEC_CYCLES=3: rsp_ready=0 for 5 cycles → rsp_* stable, req ready stays 0. rsp_valid first rises 3 cycles after accept, and after rsp_ready=1 the next accept occurs exactly one cycle after the handshake.
